jogador_automatico: RTL and testbench

Automated player for the memory game: drives the game's `iniciar` and `botoes` inputs and watches its `leds`, `ganhou`, `perdeu` and `pronto` outputs. Each round it captures the sequence the game flashes on `leds` into a 16-entry memory. After the display goes quiet, it replays the sequence as timed button presses. It sits beside `jogo_desafio_memoria` at board top level, or in a self-running bench, replacing the human player.

---
 rtl/jogador_automatico_pkg.sv | 24 ++
 rtl/jogador_automatico_if.sv | 21 ++
 rtl/jogador_automatico_memoria_jogadas.sv | 24 ++
 rtl/jogador_automatico.sv | 229 ++++++++++++++++++++++
 tb/tb_jogador_automatico.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jogador_automatico_pkg.sv
// Shared types and constants for the automated memory-game player.
// Build option: JOGADOR_ERRO_EN (see jogador_automatico.sv).
package jogador_pkg;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        INICIA    = 4'd1,
        ESCUTA    = 4'd2,
        CAPTURA   = 4'd3,
        PRESSIONA = 4'd4,
        SOLTA     = 4'd5,
        FIM       = 4'd15
    } estado_t;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int CNT_W     = 16;

    // Deliberately wrong button: left rotation of the stored pattern.
    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Signals between the automated player and the memory game.
interface jogador_automatico_if;

    logic       iniciar;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       pronto;

    modport master (
        output iniciar, botoes,
        input  leds, ganhou, perdeu, pronto
    );

    modport slave (
        input  iniciar, botoes,
        output leds, ganhou, perdeu, pronto
    );

endinterface

// File: rtl/jogador_automatico_memoria_jogadas.sv
// 16x4 register file holding one round of captured display patterns.
// Synchronous write, asynchronous read, contents are never reset.
module memoria_jogadas
    import jogador_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [3:0]        rdata
);

    logic [3:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Automated player: captures each round's display and replays it as timed presses.
// Build option: define JOGADOR_ERRO_EN to corrupt the last press of round ERRO_RODADA.
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int PRESS_CYCLES = 100,
    parameter int GAP_CYCLES   = 100,
    parameter int IDLE_CYCLES  = 50,
    parameter int START_CYCLES = 5,
    parameter int ERRO_RODADA  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 habilitar,
    jogador_automatico_if.master jogo,
    output logic                 terminou,
    output logic                 venceu,
    output logic [3:0]           db_estado,
    output logic [4:0]           db_contagem,
    output logic [4:0]           db_rodada
);

    localparam logic [3:0] ST_OCIOSO    = OCIOSO;
    localparam logic [3:0] ST_INICIA    = INICIA;
    localparam logic [3:0] ST_ESCUTA    = ESCUTA;
    localparam logic [3:0] ST_CAPTURA   = CAPTURA;
    localparam logic [3:0] ST_PRESSIONA = PRESSIONA;
    localparam logic [3:0] ST_SOLTA     = SOLTA;
    localparam logic [3:0] ST_FIM       = FIM;

    localparam logic [CNT_W-1:0] PRESS_LD  = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LD  = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
    localparam logic [4:0]       CHEIO     = 5'(MEM_DEPTH);

    logic [3:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  idle_q,     idle_d;
    logic [4:0]        count_q,    count_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [4:0]        rodada_q,   rodada_d;
    logic              iniciar_q,  iniciar_d;
    logic [3:0]        botoes_q,   botoes_d;
    logic              terminou_q, terminou_d;
    logic              venceu_q,   venceu_d;
    logic              hab_prev_q, hab_prev_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;
    logic [3:0]        mem_rdata;
    logic [3:0]        press_val;
    logic              status;

    memoria_jogadas u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (jogo.leds),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // The read port always points at the entry the next press will load.
    always_comb begin
        mem_raddr = (state_q == ST_SOLTA) ? addr_q + 1'b1 : '0;
        press_val = mem_rdata;
`ifdef JOGADOR_ERRO_EN
        if (rodada_q == 5'(ERRO_RODADA) && {1'b0, mem_raddr} == count_q - 5'd1) begin
            press_val = rotl4(mem_rdata);
        end
`endif
    end

`ifndef JOGADOR_ERRO_EN
    logic unused_erro;
    assign unused_erro = ^ERRO_RODADA;
`endif

    assign status = jogo.ganhou | jogo.perdeu | jogo.pronto;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        count_d    = count_q;
        addr_d     = addr_q;
        rodada_d   = rodada_q;
        iniciar_d  = iniciar_q;
        botoes_d   = botoes_q;
        terminou_d = terminou_q;
        venceu_d   = venceu_q;
        hab_prev_d = habilitar;
        mem_we     = 1'b0;

        case (state_q)
            ST_OCIOSO: begin
                iniciar_d  = 1'b0;
                botoes_d   = 4'd0;
                terminou_d = 1'b0;
                venceu_d   = 1'b0;
                if (habilitar) begin
                    state_d   = ST_INICIA;
                    iniciar_d = 1'b1;
                    cnt_d     = START_LD;
                end
            end
            ST_INICIA: begin
                if (cnt_q == '0) begin
                    state_d   = ST_ESCUTA;
                    iniciar_d = 1'b0;
                    count_d   = '0;
                    rodada_d  = '0;
                    idle_d    = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ESCUTA: begin
                if (jogo.leds != 4'd0) begin
                    mem_we  = (count_q != CHEIO);
                    state_d = ST_CAPTURA;
                end else if (idle_q < IDLE_MAX) begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == IDLE_LAST && count_q != '0) begin
                        state_d  = ST_PRESSIONA;
                        addr_d   = '0;
                        botoes_d = press_val;
                        cnt_d    = PRESS_LD;
                    end
                end
            end
            ST_CAPTURA: begin
                if (jogo.leds == 4'd0) begin
                    count_d = (count_q == CHEIO) ? CHEIO : count_q + 5'd1;
                    idle_d  = '0;
                    state_d = ST_ESCUTA;
                end
            end
            ST_PRESSIONA: begin
                if (cnt_q == '0) begin
                    state_d  = ST_SOLTA;
                    botoes_d = 4'd0;
                    cnt_d    = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SOLTA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if ({1'b0, addr_q} == count_q - 5'd1) begin
                    state_d  = ST_ESCUTA;
                    rodada_d = rodada_q + 5'd1;
                    count_d  = '0;
                    idle_d   = '0;
                end else begin
                    state_d  = ST_PRESSIONA;
                    addr_d   = addr_q + 1'b1;
                    botoes_d = press_val;
                    cnt_d    = PRESS_LD;
                end
            end
            ST_FIM: begin
                botoes_d   = 4'd0;
                iniciar_d  = 1'b0;
                terminou_d = 1'b1;
                if (habilitar && !hab_prev_q) begin
                    state_d    = ST_INICIA;
                    iniciar_d  = 1'b1;
                    cnt_d      = START_LD;
                    terminou_d = 1'b0;
                    venceu_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_OCIOSO;
            end
        endcase

        // Game status wins over everything once a game is under way.
        if (status && state_q != ST_OCIOSO && state_q != ST_INICIA && state_q != ST_FIM) begin
            state_d    = ST_FIM;
            venceu_d   = jogo.ganhou;
            terminou_d = 1'b1;
            botoes_d   = 4'd0;
            iniciar_d  = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_OCIOSO;
            cnt_q      <= '0;
            idle_q     <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            rodada_q   <= '0;
            iniciar_q  <= 1'b0;
            botoes_q   <= 4'd0;
            terminou_q <= 1'b0;
            venceu_q   <= 1'b0;
            hab_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            rodada_q   <= rodada_d;
            iniciar_q  <= iniciar_d;
            botoes_q   <= botoes_d;
            terminou_q <= terminou_d;
            venceu_q   <= venceu_d;
            hab_prev_q <= hab_prev_d;
        end
    end

    assign jogo.iniciar = iniciar_q;
    assign jogo.botoes  = botoes_q;
    assign terminou     = terminou_q;
    assign venceu       = venceu_q;
    assign db_estado    = state_q;
    assign db_contagem  = count_q;
    assign db_rodada    = rodada_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: a game model issues displays and queues
// the expected presses; a monitor pops and checks every completed press.
module tb_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilitar;
    logic       terminou;
    logic       venceu;
    logic [3:0] db_estado;
    logic [4:0] db_contagem;
    logic [4:0] db_rodada;

    jogador_automatico_if jif ();

    jogador_automatico dut (
        .clock       (clock),
        .reset       (reset),
        .habilitar   (habilitar),
        .jogo        (jif),
        .terminou    (terminou),
        .venceu      (venceu),
        .db_estado   (db_estado),
        .db_contagem (db_contagem),
        .db_rodada   (db_rodada)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q [$];

    logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2,
                             4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8};
    // Overflow round: entry 1 changes to 6 mid-pulse, entry 16 must be dropped.
    logic [3:0] ovf [17] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                             4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h5, 4'h9};

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v, input int on, input int off);
        jif.leds = v;
        repeat (on) step();
        jif.leds = 4'd0;
        repeat (off) step();
    endtask

    task automatic show_round(input int r);
        for (int i = 0; i <= r; i++) begin
            exp_q.push_back(seq[i]);
            pulse(seq[i], 20, (i == r) ? 0 : 10);
        end
    endtask

    task automatic wait_round(input int rod);
        int n = 0;
        while ((exp_q.size() != 0 || db_rodada != 5'(rod)) && n < 5000) begin
            step();
            n++;
        end
        chk("round rodada", db_rodada, rod);
        chk("round queue drained", exp_q.size(), 0);
    endtask

    task automatic wait_press(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (jif.botoes == 4'd0 && n < 200);
    endtask

    task automatic restart();
        habilitar = 1'b0;
        step();
        habilitar = 1'b1;
        step();
        chk("restart estado", db_estado, 1);
        chk("restart terminou", terminou, 0);
        repeat (6) step();
        chk("restart escuta", db_estado, 2);
    endtask

    // Monitor: one comparison pair per completed press.
    initial begin
        logic [3:0] val;
        int         len;
        bit         in_p;
        logic [3:0] e;
        in_p = 1'b0;
        len  = 0;
        val  = 4'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_p = 1'b0;
            end else if (!in_p && jif.botoes != 4'd0) begin
                in_p = 1'b1;
                val  = jif.botoes;
                len  = 1;
            end else if (in_p && jif.botoes != 4'd0) begin
                len++;
            end else if (in_p) begin
                in_p = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected press", val, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("press value", val, e);
                    chk("press width", len, 100);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        bit stray;
        reset     = 1'b1;
        habilitar = 1'b0;
        jif.leds   = 4'd0;
        jif.ganhou = 1'b0;
        jif.perdeu = 1'b0;
        jif.pronto = 1'b0;
        repeat (3) step();
        chk("rst iniciar", jif.iniciar, 0);
        chk("rst botoes", jif.botoes, 0);
        chk("rst terminou", terminou, 0);
        chk("rst venceu", venceu, 0);
        chk("rst estado", db_estado, 0);
        chk("rst contagem", db_contagem, 0);
        chk("rst rodada", db_rodada, 0);
        reset = 1'b0;
        step();
        chk("ocioso without habilitar", db_estado, 0);

        // Start pulse
        habilitar = 1'b1;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) chk("estado inicia", db_estado, 1);
            if (jif.iniciar) hi++;
        end
        chk("iniciar width", hi, 5);
        chk("estado escuta", db_estado, 2);

        // Round 0 with detailed timing
        exp_q.push_back(4'h1);
        jif.leds = 4'h1;
        repeat (20) step();
        chk("contagem during pulse", db_contagem, 0);
        jif.leds = 4'h0;
        step();
        chk("contagem after fall", db_contagem, 1);
        n = 1;
        while (jif.botoes == 4'd0 && n < 200) begin
            step();
            n++;
        end
        chk("replay latency", n, 51);
        chk("first press value", jif.botoes, 1);
        n = 0;
        while (jif.botoes != 4'd0 && n < 300) begin
            step();
            n++;
        end
        chk("press hold", n, 100);
        n = 0;
        stray = 1'b0;
        while (db_rodada != 5'd1 && n < 300) begin
            step();
            n++;
            if (jif.botoes != 4'd0) stray = 1'b1;
        end
        chk("gap length", n, 100);
        chk("gap quiet", stray, 0);
        chk("contagem cleared", db_contagem, 0);

        // Rounds 1..15
        for (int r = 1; r < 16; r++) begin
            repeat (5) step();
            show_round(r);
            wait_round(r + 1);
        end
        jif.ganhou = 1'b1;
        step();
        chk("win terminou", terminou, 1);
        chk("win venceu", venceu, 1);
        chk("win estado", db_estado, 15);
        chk("win botoes", jif.botoes, 0);
        jif.ganhou = 1'b0;
        step();
        chk("terminou latched", terminou, 1);

        // Overflow round: 17 pulses, 16 stored
        restart();
        for (int i = 0; i < 16; i++) exp_q.push_back(ovf[i]);
        for (int i = 0; i < 17; i++) begin
            if (i == 1) begin
                jif.leds = 4'h2;
                repeat (10) step();
                jif.leds = 4'h6;
                repeat (10) step();
                jif.leds = 4'h0;
                repeat (10) step();
            end else begin
                pulse(ovf[i], 20, (i == 16) ? 1 : 10);
            end
        end
        chk("contagem saturated", db_contagem, 16);
        wait_round(1);
        jif.pronto = 1'b1;
        step();
        chk("pronto terminou", terminou, 1);
        chk("pronto venceu", venceu, 0);
        jif.pronto = 1'b0;

`ifdef JOGADOR_ERRO_EN
        // Round 3 carries a corrupted last press: 1000 rotated left is 0001
        restart();
        for (int r = 0; r < 3; r++) begin
            repeat (5) step();
            show_round(r);
            wait_round(r + 1);
        end
        repeat (5) step();
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h1);
        pulse(4'h1, 20, 10);
        pulse(4'h2, 20, 10);
        pulse(4'h4, 20, 10);
        pulse(4'h8, 20, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        chk("error round presses", exp_q.size(), 0);
        jif.perdeu = 1'b1;
        step();
        chk("lose terminou", terminou, 1);
        chk("lose venceu", venceu, 0);
        chk("lose botoes", jif.botoes, 0);
        chk("lose estado", db_estado, 15);
        jif.perdeu = 1'b0;
`endif

        // Reset in the middle of a press
        restart();
        pulse(4'h4, 20, 0);
        wait_press(n);
        chk("second latency", n, 51);
        repeat (10) step();
        chk("pressing before reset", jif.botoes, 4);
        reset = 1'b1;
        step();
        chk("mid-press reset botoes", jif.botoes, 0);
        chk("mid-press reset iniciar", jif.iniciar, 0);
        chk("mid-press reset estado", db_estado, 0);
        chk("mid-press reset terminou", terminou, 0);
        chk("mid-press reset contagem", db_contagem, 0);
        chk("mid-press reset rodada", db_rodada, 0);
        step();
        reset = 1'b0;
        step();
        chk("queue empty at end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
